// File: rtl/riscv_mem_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_LATENCY = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_t;

endpackage

// File: rtl/riscv_mem_lat_counter.sv
// Down-counter that measures the fixed read latency of the memory macro.
module riscv_mem_lat_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  // Loading LATENCY-1 lets the zero flag line up with the cycle the read data is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing each access as IDLE -> ISSUE -> WAIT -> RESP with data given priority.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ack,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t state;
  arb_owner_t owner;
  logic       load_op;
  logic       cnt_zero;

  riscv_mem_lat_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_counter (
    .clk  (clk),
    .reset(reset),
    .load (state == ISSUE),
    .dec  (state == WAIT),
    .zero (cnt_zero)
  );

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_INSTR;
      load_op   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          // A MEM-stage stall freezes the whole pipeline, so data always wins a tie.
          if (d_req) begin
            owner     <= OWN_DATA;
            load_op   <= ~d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : '1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ISSUE;
          end else if (i_req) begin
            owner    <= OWN_INSTR;
            load_op  <= 1'b1;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= '1;
            mem_addr <= i_addr;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cnt_zero) begin
            if (owner == OWN_INSTR) begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              if (load_op) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: vector table, corner-case sequences
// and randomized traffic checked against a word-array memory reference.
module tb_riscv_mem_arbiter;

  localparam int LAT   = 2;
  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic logic [31:0] init_word(input int w);
    case (w)
      0:       return 32'h0000_0297;
      1:       return 32'h0040_0313;
      2:       return 32'h00A0_0393;
      4:       return 32'h0051_0093;
      8:       return 32'h0000_0013;
      16:      return 32'hCAFE_F00D;
      64:      return 32'hDEAD_BEEF;
      default: return 32'h5A00_0000 + 32'(w) * 32'h0001_0203;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory macro: byte-writable word array, read data valid exactly LAT cycles after mem_en.
  logic [31:0] mac_mem  [0:WORDS-1];
  bit          written  [0:WORDS-1];
  logic [31:0] pend_data[0:15];
  int          pend_due [0:15];

  function automatic logic [31:0] mac_word(input int w);
    return written[w] ? mac_mem[w] : init_word(w);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mac_mem[int'(mem_addr[8:2])] <= merge(mac_word(int'(mem_addr[8:2])), mem_wdata, mem_be);
        written[int'(mem_addr[8:2])] <= 1'b1;
      end else begin
        pend_data[(cyc + LAT) % 16] <= mac_word(int'(mem_addr[8:2]));
        pend_due[(cyc + LAT) % 16]  <= cyc + LAT;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    mem_rdata <= (pend_due[cyc % 16] == cyc) ? pend_data[cyc % 16] : $urandom;
  end

  // Requester protocol: request fields must stay stable until acked.
  bit          i_pend_q, d_pend_q;
  logic [31:0] i_addr_q;
  logic [68:0] d_fields_q;
  always @(posedge clk) begin
    if (!reset && i_pend_q && i_req)
      assert (i_addr == i_addr_q) else $error("protocol violation: i_addr changed while pending");
    if (!reset && d_pend_q && d_req)
      assert ({d_we, d_be, d_addr, d_wdata} == d_fields_q) else $error("protocol violation: data request changed while pending");
    i_pend_q   <= i_req & ~i_ack;
    d_pend_q   <= d_req & ~d_ack;
    i_addr_q   <= i_addr;
    d_fields_q <= {d_we, d_be, d_addr, d_wdata};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reqs();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // One request from the IDLE cycle (cycle 0) to its ack; leaves req asserted.
  task automatic do_txn(input bit is_data, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int ack_cyc);
    int k, lat, en_cnt, en_at;
    bit done, stall_ok, we_leak;
    logic en_we;
    logic [3:0] en_be;
    logic [31:0] en_addr, en_wd;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    k = 0; lat = -1; done = 0; en_cnt = 0; en_at = -1; stall_ok = 1; we_leak = 0;
    en_we = 1'b0; en_be = '0; en_addr = '0; en_wd = '0; rdata = '0; ack_cyc = -1;
    while (!done && k < 40) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++; en_at = k; en_we = mem_we; en_be = mem_be; en_addr = mem_addr; en_wd = mem_wdata;
      end else if (mem_we) begin
        we_leak = 1;
      end
      if (is_data ? d_ack : i_ack) begin
        done = 1; lat = k; ack_cyc = cyc;
        rdata = is_data ? d_rdata : i_rdata;
        if (is_data ? d_stall : i_stall) stall_ok = 0;
      end else if (!(is_data ? d_stall : i_stall)) begin
        stall_ok = 0;
      end
      k++;
      tick();
    end
    $display("txn port=%s we=%0d addr=0x%08h lat=%0d rdata=0x%08h", is_data ? "D" : "I", we, addr, lat, rdata);
    check("ack_latency", 64'(lat), 64'(LAT + 2));
    check("mem_en_count", 64'(en_cnt), 64'd1);
    check("mem_en_cycle", 64'(en_at), 64'd1);
    check("mem_addr", 64'(en_addr), 64'(addr));
    check("mem_we", 64'(en_we), 64'(we));
    check("mem_be", 64'(en_be), 64'(we ? be : 4'hF));
    if (we) check("mem_wdata", 64'(en_wd), 64'(wdata));
    check("mem_we_when_idle", 64'(we_leak), 64'd0);
    check("stall", 64'(stall_ok), 64'd1);
  endtask

  typedef struct {
    bit          is_data;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] ref_mem[0:WORDS-1];

  initial begin
    logic [31:0] rd, exp_v, last_d;
    int ackc, a0, a1, a2, dack_at, iack_at, bad, acks_seen;
    int en_cycles[$];
    logic [31:0] d_val, i_val, addr;
    bit is_d, we;
    logic [3:0] be;
    int w;

    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h0051_0093};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'h1234_ABCD, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,         32'hCAFE_ABCD};
    vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h0000_0040, 32'h5566_7788, 32'hCAFE_ABCD};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0,         32'h5566_ABCD};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,         32'h5566_ABCD};
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);

    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: nothing happens, registered outputs are cleared.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en || mem_we || i_ack || d_ack || i_stall || d_stall) bad++;
    end
    check("idle_activity", 64'(bad), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_mem_be", 64'(mem_be), 64'd0);
    check("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    check("reset_i_rdata", 64'(i_rdata), 64'd0);
    check("reset_d_rdata", 64'(d_rdata), 64'd0);
    tick();

    // Vector table: fetch, load, partial stores, read-back through both ports.
    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].is_data, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, ackc);
      check($sformatf("vec%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rdata));
      if (vecs[v].we)
        ref_mem[int'(vecs[v].addr[8:2])] = merge(ref_mem[int'(vecs[v].addr[8:2])], vecs[v].wdata, vecs[v].be);
      release_reqs();
      tick();
    end

    // Collision: data load wins, fetch follows once d_req drops.
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100; d_wdata = 0;
    dack_at = -1; iack_at = -1; d_val = 0; i_val = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_en) en_cycles.push_back(k);
      if (d_ack) begin dack_at = k; d_val = d_rdata; end
      if (i_ack) begin iack_at = k; i_val = i_rdata; end
      tick();
      if (dack_at == k) d_req = 0;
      if (iack_at == k) begin i_req = 0; break; end
    end
    $display("txn collision d_ack=%0d i_ack=%0d d_rdata=0x%08h i_rdata=0x%08h", dack_at, iack_at, d_val, i_val);
    check("coll_d_ack_cycle", 64'(dack_at), 64'(LAT + 2));
    check("coll_d_rdata", 64'(d_val), 64'hDEAD_BEEF);
    check("coll_i_ack_cycle", 64'(iack_at), 64'(2 * LAT + 5));
    check("coll_i_rdata", 64'(i_val), 64'h0000_0013);
    check("coll_mem_en_count", 64'(en_cycles.size()), 64'd2);
    if (en_cycles.size() >= 2) check("coll_fetch_issue_cycle", 64'(en_cycles[1]), 64'(LAT + 4));
    tick();

    // Back-to-back fetches with i_req held across the acks.
    do_txn(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, rd, a0);
    check("b2b_rdata0", 64'(rd), 64'h0000_0297);
    do_txn(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, rd, a1);
    check("b2b_rdata1", 64'(rd), 64'h0040_0313);
    do_txn(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, rd, a2);
    check("b2b_rdata2", 64'(rd), 64'h00A0_0393);
    check("b2b_spacing01", 64'(a1 - a0), 64'(LAT + 3));
    check("b2b_spacing12", 64'(a2 - a1), 64'(LAT + 3));
    release_reqs();
    tick();

    // Reset in the middle of WAIT: the in-flight load must vanish without an ack.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 0;
    repeat (3) tick();
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    @(negedge clk);
    check("rst_wait_mem_en", 64'(mem_en), 64'd0);
    check("rst_wait_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_wait_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_wait_mem_addr", 64'(mem_addr), 64'd0);
    acks_seen = (d_ack || i_ack) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_ack || i_ack) acks_seen++;
    end
    check("rst_wait_no_ack", 64'(acks_seen), 64'd0);
    tick();
    do_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, rd, ackc);
    check("post_reset_load", 64'(rd), 64'hDEAD_BEEF);
    last_d = 32'hDEAD_BEEF;
    release_reqs();
    tick();

    // Randomized traffic against the reference word array.
    for (int n = 0; n < 60; n++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d & 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(1, 15));
      w    = $urandom_range(0, WORDS - 1);
      addr = 32'(w) << 2;
      d_val = $urandom;
      exp_v = we ? last_d : ref_mem[w];
      do_txn(is_d, we, be, addr, d_val, rd, ackc);
      check($sformatf("rand%0d_rdata", n), 64'(rd), 64'(exp_v));
      if (we) ref_mem[w] = merge(ref_mem[w], d_val, be);
      else if (is_d) last_d = exp_v;
      release_reqs();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1);
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the RISC-V fetch stage (instruction port, read-only) and the load/store stage (data port, read/write).
- Sits between RISC_V_Processor's IF/MEM stages and the memory macro.
- Sequences each access through a fixed-latency memory protocol and returns a one-cycle ack per request; the pipeline stalls on the stall outputs.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata is valid this cycle.
- i_rdata  out  DATA_W  fetched instruction.
- i_stall  out  1  i_req & ~i_ack (combinational).
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse (loads and stores).
- d_rdata  out  DATA_W  load data; updated only on load completion.
- d_stall  out  1  d_req & ~d_ack (combinational).
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_be  out  DATA_W/8  byte enables; all ones for reads.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except i_stall and d_stall.
- IDLE:
  - If d_req is high: latch owner=DATA, d_we, d_be, d_addr, d_wdata, then go to ISSUE.
  - Else if i_req is high: latch owner=INSTR and i_addr; mem_we=0, mem_be=all ones; go to ISSUE.
  - Else stay in IDLE.
  - Data has fixed priority, because a MEM-stage stall freezes the whole pipeline.
- ISSUE: mem_en=1 for exactly this cycle with the latched mem_* values. Load cnt=MEM_LATENCY-1, then go to WAIT.
- WAIT:
  - If cnt==0: sample mem_rdata into the owner's rdata register (data port: loads only), then go to RESP.
  - Else decrement cnt.
  - At cnt==0 the cycle is exactly MEM_LATENCY cycles after ISSUE.
- RESP: owner's ack=1 for exactly one cycle; rdata holds its value until the next completion for that port. Go to IDLE.
- Latency: request first seen in IDLE at cycle 0 → ack at cycle MEM_LATENCY+2. Back-to-back accesses occupy MEM_LATENCY+3 cycles each.
- Requester protocol: deassert req, or present a new request, in the cycle after ack. Req high in IDLE is always treated as a new request. Address and data changes while req is high and unacked are a protocol violation (bench assertion).
- A request arriving while the FSM is busy waits. Its stall stays high; no state is lost.
- Simultaneous i_req and d_req in IDLE: data is served first; instruction is granted in the following IDLE if d_req has dropped.
- Back-to-back data requests can starve fetch. This is accepted: the pipeline cannot issue new data requests without new fetches.
- mem_we=0 whenever mem_en=0. mem_addr, mem_wdata and mem_be hold their last values between accesses.
- Reset (any state, including mid-WAIT):
  - Next cycle is IDLE with cnt=0.
  - mem_en, mem_we, i_ack and d_ack are 0; mem_be, mem_addr, mem_wdata, i_rdata and d_rdata are 0.
  - In-flight memory data is discarded; no ack is produced for it.

Decomposition:
- Package riscv_mem_pkg:
  - typedef enum {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  - typedef enum {OWN_INSTR, OWN_DATA} arb_owner_t;
  - localparams for the default widths.
- One sub-module: riscv_mem_lat_counter (load, decrement, zero flag, width $clog2(MEM_LATENCY+1)).
- Everything else stays flat in riscv_mem_arbiter.

Test Plan:
- Reset then idle, MEM_LATENCY=1: no req for 10 cycles → mem_en=0 and both acks 0 throughout; all registered outputs 0.
- Single fetch: i_req, i_addr=0x0000_0010, model returns 0x0051_0093 → mem_en on cycle 1 with mem_addr=0x10, mem_we=0; i_ack at cycle 3 with i_rdata=0x0051_0093. i_stall is high on cycles 0–2.
- Collision, MEM_LATENCY=2: i_req(0x20) and d_req load (0x100 → 0xDEADBEEF) in the same cycle → d_ack at cycle 4 with d_rdata=0xDEADBEEF; fetch mem_en at cycle 6; i_ack at cycle 9.
- Store: d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0x1234_ABCD → mem_en with mem_we=1 and mem_be=0011 for exactly one cycle; d_ack at cycle 3; d_rdata unchanged.
- Reset mid-WAIT, MEM_LATENCY=4: reset at cycle 3 of a load → FSM in IDLE next cycle; no d_ack ever issued for that load. A new request after reset completes normally with the correct latency.
- Back-to-back fetches: i_req held continuously across 3 acks with changing addresses 0x0, 0x4, 0x8 → acks exactly MEM_LATENCY+3 cycles apart, with the matching rdata each time.
